// File: rtl/mac_feeder.sv
// rtl/mac_feeder.sv - operand sequencer feeding the mac accumulator
//
// Holds operand vectors A and B written by the host. A start request clears
// the mac, streams A[i]/B[i] one pair per cycle, waits one cycle for the final
// accumulate, captures acc/of into a held result and pulses done.
// Zeros are driven to the mac whenever not streaming.
//
// Ports:
//   clk, r                  clock (rising edge), async active-low reset
//   wr_en/wr_sel/wr_addr/wr_data  host buffer write (sel 0 = A, 1 = B), IDLE only
//   len, start              run length and run request (sampled in IDLE)
//   busy                    high whenever not IDLE
//   mac_clr, mac_a, mac_b   clear and operands to the mac
//   acc_in, of_in           mac accumulator value and overflow flag
//   result, result_of, done captured result, overflow, one-cycle valid pulse
//   err                     sticky bad-length flag
//
// Optional: MAC_FEEDER_LENCHK_EN rejects starts with len=0 or len>DEPTH and
// sets err; without it err is 0 and such lengths run empty/clamped.

module mac_feeder #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          r,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW:0]   len,
  input  logic          start,
  output logic          busy,
  output logic          mac_clr,
  output logic [DW-1:0] mac_a,
  output logic [DW-1:0] mac_b,
  input  logic [15:0]   acc_in,
  input  logic          of_in,
  output logic [15:0]   result,
  output logic          result_of,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  state_e        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   idx_q, idx_d;
  logic          err_q, err_d;
  logic [15:0]   result_q, result_d;
  logic          result_of_q, result_of_d;
  logic          busy_q, mac_clr_q, done_q;
  logic [DW-1:0] mac_a_q, mac_a_d;
  logic [DW-1:0] mac_b_q, mac_b_d;
  logic [DW-1:0] buf_a_q [DEPTH];
  logic [DW-1:0] buf_b_q [DEPTH];
  logic [AW:0]   len_clamped;

  assign len_clamped = (len > DEPTH_L) ? DEPTH_L : len;

`ifdef MAC_FEEDER_LENCHK_EN
  logic len_bad;
  assign len_bad = (len == '0) || (len > DEPTH_L);
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    err_d       = err_q;
    result_d    = result_q;
    result_of_d = result_of_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef MAC_FEEDER_LENCHK_EN
          if (len_bad) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            cnt_d   = len_clamped;
            idx_d   = '0;
            state_d = S_CLR;
          end
`else
          cnt_d   = len_clamped;
          idx_d   = '0;
          state_d = S_CLR;
`endif
        end
      end
      S_CLR: begin
        idx_d   = '0;
        // an empty run skips straight to the capture cycle
        state_d = (cnt_q == '0) ? S_DRAIN : S_STREAM;
      end
      S_STREAM: begin
        if (idx_q == cnt_q - ONE_L) state_d = S_DRAIN;
        else                        idx_d   = idx_q + ONE_L;
      end
      S_DRAIN: begin
        // last operand pair was accumulated on the previous edge
        result_d    = acc_in;
        result_of_d = of_in;
        state_d     = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs are registered from the next state so they line up with it
  always_comb begin
    mac_a_d = '0;
    mac_b_d = '0;
    if (state_d == S_STREAM) begin
      mac_a_d = buf_a_q[idx_d[AW-1:0]];
      mac_b_d = buf_b_q[idx_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      result_q    <= '0;
      result_of_q <= 1'b0;
      busy_q      <= 1'b0;
      mac_clr_q   <= 1'b0;
      done_q      <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_a_q[i] <= '0;
        buf_b_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      result_q    <= result_d;
      result_of_q <= result_of_d;
      busy_q      <= (state_d != S_IDLE);
      mac_clr_q   <= (state_d == S_CLR);
      done_q      <= (state_d == S_DONE);
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      // buffers are frozen for the duration of a run
      if (wr_en && (state_q == S_IDLE)) begin
        if (wr_sel) buf_b_q[wr_addr] <= wr_data;
        else        buf_a_q[wr_addr] <= wr_data;
      end
    end
  end

  assign busy      = busy_q;
  assign mac_clr   = mac_clr_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign result    = result_q;
  assign result_of = result_of_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mac_feeder.sv
// tb/tb_mac_feeder.sv - self-checking bench for mac_feeder with a saturating mac model

module tb_mac_feeder;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          r = 1'b0;
  logic          wr_en = 1'b0;
  logic          wr_sel = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [AW:0]   len = '0;
  logic          start = 1'b0;
  logic          busy, mac_clr, done, err, result_of;
  logic [DW-1:0] mac_a, mac_b;
  logic [15:0]   result;

  logic [15:0]   acc = 16'd0;
  logic          ovf = 1'b0;
  logic [17:0]   mac_sum;

  int            total = 0;
  int            bad = 0;
  logic [16:0]   sb_q[$];
  logic [DW-1:0] seen_a [64];
  logic [DW-1:0] seen_b [64];
  logic          seen_clr [64];

  mac_feeder #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .r         (r),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .len       (len),
    .start     (start),
    .busy      (busy),
    .mac_clr   (mac_clr),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .acc_in    (acc),
    .of_in     (ovf),
    .result    (result),
    .result_of (result_of),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // downstream mac: accumulates every cycle, saturates at 16 bits, sticky overflow
  assign mac_sum = 18'(acc) + 18'(mac_a) * 18'(mac_b);
  always @(posedge clk) begin
    if (mac_clr) begin
      acc <= 16'd0;
      ovf <= 1'b0;
    end else begin
      acc <= (mac_sum > 18'd65535) ? 16'hFFFF : mac_sum[15:0];
      ovf <= ovf | (mac_sum > 18'd65535);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic sel, input int addr, input logic [DW-1:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = AW'(addr);
    wr_data = data;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic load(input logic [DW-1:0] a [8], input logic [DW-1:0] b [8]);
    for (int i = 0; i < DEPTH; i++) begin
      wr(1'b0, i, a[i]);
      wr(1'b1, i, b[i]);
    end
  endtask

  // start a run, push the expected result, wait for done, pop and compare;
  // poke > 0 injects a start plus a write to A[0] in that cycle
  task automatic run(input string tag, input logic [AW:0] n, input logic [15:0] er,
                     input logic eo, input int ecyc, input int poke);
    int cyc;
    bit found;
    int extra;
    logic [16:0] exp_v;
    sb_q.push_back({eo, er});
    len   = n;
    start = 1'b1;
    step();
    start = 1'b0;
    wr_en = 1'b0;
    cyc   = 1;
    found = 1'b0;
    chk({tag, "_err_c1"}, 32'(err), 32'd0);
    chk({tag, "_busy_c1"}, 32'(busy), 32'd1);
    while (!found && cyc < 40) begin
      seen_a[cyc]   = mac_a;
      seen_b[cyc]   = mac_b;
      seen_clr[cyc] = mac_clr;
      if (done) begin
        found = 1'b1;
      end else begin
        if (cyc == poke) begin
          start   = 1'b1;
          wr_en   = 1'b1;
          wr_sel  = 1'b0;
          wr_addr = '0;
          wr_data = 8'd77;
        end
        step();
        start = 1'b0;
        wr_en = 1'b0;
        cyc++;
      end
    end
    chk({tag, "_done_seen"}, 32'(found), 32'd1);
    chk({tag, "_done_cycle"}, 32'(cyc), 32'(ecyc));
    exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 17'h1FFFF;
    chk({tag, "_result"}, 32'(result), 32'(exp_v[15:0]));
    chk({tag, "_result_of"}, 32'(result_of), 32'(exp_v[16]));
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (done) extra++;
    end
    chk({tag, "_extra_done"}, 32'(extra), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_result_held"}, 32'(result), 32'(exp_v[15:0]));
  endtask

  initial begin
    logic [DW-1:0] va [8];
    logic [DW-1:0] vb [8];
    int dn;

    // reset state
    r = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mac_clr", 32'(mac_clr), 32'd0);
    chk("rst_mac_a", 32'(mac_a), 32'd0);
    chk("rst_mac_b", 32'(mac_b), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_result_of", 32'(result_of), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    r = 1'b1;
    step();

    // basic 4-element dot product with operand timing
    va = '{6, 5, 9, 3, 0, 0, 0, 0};
    vb = '{9, 4, 2, 8, 0, 0, 0, 0};
    load(va, vb);
    run("t1", 4'd4, 16'd116, 1'b0, 7, -1);
    chk("t1_clr_c1", 32'(seen_clr[1]), 32'd1);
    chk("t1_a_c1", 32'(seen_a[1]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_a_c%0d", i + 2), 32'(seen_a[i + 2]), 32'(va[i]));
      chk($sformatf("t1_b_c%0d", i + 2), 32'(seen_b[i + 2]), 32'(vb[i]));
    end
    chk("t1_a_drain", 32'(seen_a[6]), 32'd0);
    chk("t1_clr_c2", 32'(seen_clr[2]), 32'd0);

    // saturation then a clean rerun
    va = '{255, 40, 0, 0, 0, 0, 0, 0};
    vb = '{255, 40, 0, 0, 0, 0, 0, 0};
    load(va, vb);
    run("t2a", 4'd2, 16'd65535, 1'b1, 5, -1);
    va = '{6, 5, 3, 0, 0, 0, 0, 0};
    vb = '{7, 5, 11, 0, 0, 0, 0, 0};
    load(va, vb);
    run("t2b", 4'd3, 16'd100, 1'b0, 6, -1);
    chk("t2b_clr_c1", 32'(seen_clr[1]), 32'd1);

    // len=1 with A[0] written on the start edge
    wr(1'b1, 0, 8'd2);
    wr_en   = 1'b1;
    wr_sel  = 1'b0;
    wr_addr = '0;
    wr_data = 8'd255;
    run("t3a", 4'd1, 16'd510, 1'b0, 4, -1);

`ifdef MAC_FEEDER_LENCHK_EN
    len   = 4'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t3b_err", 32'(err), 32'd1);
    chk("t3b_busy", 32'(busy), 32'd0);
    step();
`else
    run("t3b", 4'd0, 16'd0, 1'b0, 3, -1);
`endif

    // start and write during STREAM are ignored
    va = '{6, 5, 9, 3, 0, 0, 0, 0};
    vb = '{9, 4, 2, 8, 0, 0, 0, 0};
    load(va, vb);
    run("t4", 4'd4, 16'd116, 1'b0, 7, 3);

    // reset in the middle of a len=8 run
    for (int i = 0; i < 8; i++) begin
      va[i] = DW'(i + 1);
      vb[i] = 8'd2;
    end
    load(va, vb);
    len   = 4'd8;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    r = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_mac_a", 32'(mac_a), 32'd0);
    chk("t5_mac_b", 32'(mac_b), 32'd0);
    chk("t5_result", 32'(result), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    step();
    r  = 1'b1;
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done) dn++;
    end
    chk("t5_no_done", 32'(dn), 32'd0);
    load(va, vb);
    run("t5", 4'd8, 16'd72, 1'b0, 11, -1);

`ifdef MAC_FEEDER_LENCHK_EN
    len   = 4'd9;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_err", 32'(err), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    step();
    chk("t6_err_sticky", 32'(err), 32'd1);
    chk("t6_busy_idle", 32'(busy), 32'd0);
    run("t6b", 4'd2, 16'd6, 1'b0, 5, -1);
`else
    run("t6", 4'd9, 16'd72, 1'b0, 11, -1);
    chk("t6_err_tied", 32'(err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_feeder.md
Name: mac_feeder

Overview:
Operand sequencer directly upstream of the mac accumulator. Holds two small operand vectors (A, B) written by the host. On start it clears the mac, streams A[i]/B[i] pairs one per cycle, waits for the final accumulate, then captures acc/of into a held result with a one-cycle done pulse. Drives zeros to the mac whenever not streaming, because the mac accumulates every cycle.

Parameters:
DEPTH, 8, max vector length (entries per buffer)
AW, 3, buffer address width, clog2(DEPTH)
DW, 8, operand width; must match mac a/b width

Ports:
clk  in  1  system clock, rising edge
r  in  1  reset, asynchronous, active-low
wr_en  in  1  buffer write strobe
wr_sel  in  1  0 = write buffer A, 1 = write buffer B
wr_addr  in  AW  buffer entry index
wr_data  in  DW  write data
len  in  AW+1  vector length for next run
start  in  1  run request, sampled in IDLE only
busy  out  1  high in any state except IDLE
mac_clr  out  1  active-high clear to the mac reset input
mac_a  out  DW  operand A to mac
mac_b  out  DW  operand B to mac
acc_in  in  16  mac accumulator value
of_in  in  1  mac overflow flag
result  out  16  captured dot product, held until next capture
result_of  out  1  captured overflow flag
done  out  1  one-cycle pulse, result valid
err  out  1  bad-length flag (see Optional Feature)

Behaviour:
- Reset (r=0, async): FSM to IDLE; busy=0, mac_clr=0, mac_a=mac_b=0, result=0, result_of=0, done=0, err=0; all buffer entries cleared to 0.
- States: IDLE -> CLR -> STREAM -> DRAIN -> DONE -> IDLE. All outputs registered.
- IDLE: mac_a=mac_b=0. On start=1, latch len into an internal count; go to CLR.
- CLR (1 cycle): mac_clr=1, operands 0.
- STREAM (len cycles): index i = 0..len-1; mac_a=A[i], mac_b=B[i]; mac_clr=0.
- DRAIN (1 cycle): operands 0; acc_in now final; result<=acc_in, result_of<=of_in at this cycle's end.
- DONE (1 cycle): done=1, then back to IDLE.
- Timing: start sampled at edge 0 -> CLR cycle 1, STREAM cycles 2..len+1, DRAIN len+2, done high in cycle len+3.
- len=0: CLR -> DRAIN directly; result=0.
- len>DEPTH: clamped to DEPTH.
- start while busy: ignored, with no queueing.
- wr_en while busy: ignored, so buffers are frozen during a run. wr_en in IDLE: writes on the same edge. A write and a start on the same edge: the write lands, and the run sees the new data.
- r asserted mid-run: immediate IDLE, result cleared, no done. The mac clears because mac_clr is re-issued on the next run.
- result/result_of are held stable between done pulses.

Optional Feature:
Macro MAC_FEEDER_LENCHK_EN.
- Defined: start with len=0 or len>DEPTH does not start a run; state stays IDLE, busy stays 0, and err is set sticky. err clears on the next accepted start or on reset.
- Undefined: err is tied 0; len=0 and len>DEPTH are handled as clamped/empty runs as described in Behaviour.

Test Plan:
- Write A=[6,5,9,3], B=[9,4,2,8]; len=4; pulse start -> mac_a/mac_b sequence 6/9, 5/4, 9/2, 3/8 in cycles 2..5; done in cycle 7; result=116, result_of=0.
- A=[255,40], B=[255,40], len=2 -> result=65535, result_of=1. Second run A=[6,5,3], B=[7,5,11], len=3 -> mac_clr seen, result=100, result_of=0.
- len=1, A[0]=255, B[0]=2 -> done in cycle 4, result=510. len=0 (macro off) -> done in cycle 3, result=0.
- Start pulse plus wr_en to A[0] during STREAM of a len=4 run -> both ignored; result matches the original data; a single done pulse.
- Assert r=0 during STREAM of a len=8 run -> busy=0, operands 0, result=0 immediately, no done. Rerun gives the correct sum.
- Macro on: len=9 start -> err=1, busy stays 0. Then len=2 start -> err=0, normal done.
